// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings, ALU ops and pipeline-register layouts for mips_cpu.
package mips_pkg;
  localparam logic [5:0] OP_R = 6'h00, OP_MUL = 6'h1C, OP_ADDI = 6'h08, OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_J = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A, FN_MUL = 6'h02;
  localparam logic [31:0] NOP = 32'h0;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MUL} alu_op_t;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } if_id_t;
  typedef struct packed {
    alu_op_t op;
    logic [31:0] a, b, sd, pc4, br_off;
    logic [4:0] dst;
    logic rw, mr, mw, beq;
  } id_ex_t;
  typedef struct packed {
    logic [31:0] res, sd;
    logic [4:0] dst;
    logic rw, mr, mw;
  } ex_mem_t;
  typedef struct packed {
    logic [31:0] res;
    logic [4:0] dst;
    logic rw;
  } mem_wb_t;
  function automatic logic r_ok(input logic [5:0] fn);
    return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  endfunction
  function automatic alu_op_t r_op(input logic [5:0] fn);
    return fn == FN_SUB ? ALU_SUB : fn == FN_AND ? ALU_AND : fn == FN_OR ? ALU_OR :
           fn == FN_SLT ? ALU_SLT : ALU_ADD;
  endfunction
endpackage

// File: rtl/mips_alu.sv
// mips_alu: integer ALU with zero flag; all arithmetic wraps modulo 2^32.
module mips_alu
  import mips_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        zero
);
  assign y = op == ALU_SUB ? a - b :
             op == ALU_AND ? a & b :
             op == ALU_OR  ? a | b :
             op == ALU_SLT ? {31'd0, $signed(a) < $signed(b)} :
             op == ALU_MUL ? a * b : a + b;
  assign zero = y == '0;
endmodule

// File: rtl/mips_regfile.sv
// mips_regfile: 32x32 register file, 2 combinational reads with write-through, r0 hardwired to 0.
module mips_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] qa,
  output logic [31:0] qb
);
  logic [31:0] r [32];
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < 32; i++) r[i] <= '0;
    else if (we && wa != 5'd0) r[wa] <= wd;
  end
  assign qa = ra == 5'd0 ? '0 : (we && wa == ra) ? wd : r[ra];
  assign qb = rb == 5'd0 ? '0 : (we && wa == rb) ? wd : r[rb];
endmodule

// File: rtl/mips_cpu.sv
// mips_cpu: 5-stage MIPS-subset pipeline (no interlocks); J resolves in ID, BEQ in EX.
module mips_cpu
  import mips_pkg::*;
(
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] Prog_BUS_READ,
  output logic [31:0] ADDR_Prog,
  output logic        CS_P,
  input  logic [31:0] Data_BUS_READ,
  output logic [31:0] ADDR,
  output logic [31:0] Data_BUS_WRITE,
  output logic        CS,
  output logic        WE
);
  logic [31:0] pc, rs_val, rt_val, imm, alu_y;
  logic cs_p, alu_z, taken, is_j, mem_op;
  logic [5:0] op, fn;
  if_id_t if_id;
  id_ex_t id_ex, d;
  ex_mem_t ex_mem;
  mem_wb_t mem_wb;
  mips_regfile rf (
    .clk(CLK), .rst(reset), .ra(if_id.instr[25:21]), .rb(if_id.instr[20:16]),
    .we(mem_wb.rw), .wa(mem_wb.dst), .wd(mem_wb.res), .qa(rs_val), .qb(rt_val)
  );
  mips_alu alu (.op(id_ex.op), .a(id_ex.a), .b(id_ex.b), .y(alu_y), .zero(alu_z));
  assign op = if_id.instr[31:26];
  assign fn = if_id.instr[5:0];
  assign imm = {{16{if_id.instr[15]}}, if_id.instr[15:0]};
  assign is_j = op == OP_J;
  assign taken = id_ex.beq && alu_z;
  always_comb begin
    d = '0;
    d.a = rs_val;
    d.b = imm;
    d.sd = rt_val;
    d.pc4 = if_id.pc4;
    d.br_off = {imm[29:0], 2'b00};
    case (op)
      OP_R:    begin d.b = rt_val; d.dst = if_id.instr[15:11]; d.rw = r_ok(fn); d.op = r_op(fn); end
      OP_MUL:  begin d.b = rt_val; d.dst = if_id.instr[15:11]; d.rw = fn == FN_MUL; d.op = ALU_MUL; end
      OP_ADDI: begin d.dst = if_id.instr[20:16]; d.rw = 1'b1; end
      OP_LW:   begin d.dst = if_id.instr[20:16]; d.rw = 1'b1; d.mr = 1'b1; end
      OP_SW:   d.mw = 1'b1;
      OP_BEQ:  begin d.b = rt_val; d.beq = 1'b1; d.op = ALU_SUB; end
      default: ;
    endcase
  end
  // a taken BEQ is older than anything in ID, so it overrides a J there
  always_ff @(posedge CLK) begin
    if (reset) begin
      pc <= '0;
      cs_p <= 1'b0;
      if_id <= '0;
      id_ex <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else begin
      cs_p <= 1'b1;
      pc <= taken ? id_ex.pc4 + id_ex.br_off :
            is_j ? {if_id.pc4[31:28], if_id.instr[25:0], 2'b00} : pc + 32'd4;
      if_id.instr <= (taken || is_j) ? NOP : Prog_BUS_READ;
      if_id.pc4 <= pc + 32'd4;
      id_ex <= taken ? '0 : d;
      ex_mem.res <= alu_y;
      ex_mem.sd <= id_ex.sd;
      ex_mem.dst <= id_ex.dst;
      ex_mem.rw <= id_ex.rw;
      ex_mem.mr <= id_ex.mr;
      ex_mem.mw <= id_ex.mw;
      mem_wb.res <= ex_mem.mr ? Data_BUS_READ : ex_mem.res;
      mem_wb.dst <= ex_mem.dst;
      mem_wb.rw <= ex_mem.rw;
    end
  end
  assign mem_op = ex_mem.mr | ex_mem.mw;
  assign ADDR_Prog = pc;
  assign CS_P = cs_p;
  assign CS = mem_op;
  assign WE = ex_mem.mw;
  assign ADDR = mem_op ? ex_mem.res : '0;
  assign Data_BUS_WRITE = ex_mem.mw ? ex_mem.sd : '0;
endmodule

// File: tb/tb_mips_cpu.sv
// tb_mips_cpu: directed programs with a scoreboard of expected data-bus operations per cycle.
module tb_mips_cpu;
  logic CLK = 1'b0, reset = 1'b1;
  logic [31:0] Prog_BUS_READ, ADDR_Prog, Data_BUS_READ, ADDR, Data_BUS_WRITE;
  logic CS_P, CS, WE;
  logic [31:0] imem [128];
  typedef struct {int cyc; logic we; logic [31:0] addr; logic [31:0] data;} mop_t;
  mop_t sb[$];
  int checks = 0, errors = 0;
  bit br = 1'b0;

  mips_cpu dut (
    .CLK(CLK), .reset(reset), .Prog_BUS_READ(Prog_BUS_READ), .ADDR_Prog(ADDR_Prog), .CS_P(CS_P),
    .Data_BUS_READ(Data_BUS_READ), .ADDR(ADDR), .Data_BUS_WRITE(Data_BUS_WRITE), .CS(CS), .WE(WE)
  );

  always #5 CLK = ~CLK;
  assign Prog_BUS_READ = imem[ADDR_Prog[8:2]];
  assign Data_BUS_READ = (ADDR == 32'h4) ? 32'h22b4 : 32'hdeadbeef;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] rt(input logic [5:0] o, input logic [5:0] f, input logic [4:0] s, input logic [4:0] t, input logic [4:0] dd);
    return {o, s, t, dd, 5'd0, f};
  endfunction
  function automatic logic [31:0] it(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t, input logic [15:0] i);
    return {o, s, t, i};
  endfunction
  function automatic logic [31:0] epc(input int c);
    if (br && c >= 13) return 32'h100 + 32'(4 * (c - 13));
    if (br && c == 11) return 32'h2c;
    if (br && c == 12) return 32'h30;
    return 32'(4 * c);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic reset_chk();
    chk("rst_pc", ADDR_Prog, 0);
    chk("rst_cs_p", CS_P, 0);
    chk("rst_addr", ADDR, 0);
    chk("rst_wdata", Data_BUS_WRITE, 0);
    chk("rst_cs", CS, 0);
    chk("rst_we", WE, 0);
  endtask
  task automatic do_reset(input int n);
    @(negedge CLK);
    reset = 1'b1;
    repeat (n) begin
      @(negedge CLK);
      reset_chk();
    end
    reset = 1'b0;
  endtask
  task automatic run(input int last);
    mop_t e;
    for (int c = 1; c <= last; c++) begin
      @(negedge CLK);
      chk("pc", ADDR_Prog, epc(c));
      chk("cs_p", CS_P, 1);
      if (CS) begin
        if (sb.size() == 0) chk("extra_cs", CS, 0);
        else begin
          e = sb.pop_front();
          chk("mop_cycle", 32'(c), 32'(e.cyc));
          chk("we", WE, e.we);
          chk("addr", ADDR, e.addr);
          if (e.we) chk("wdata", Data_BUS_WRITE, e.data);
        end
      end else begin
        chk("idle_we", WE, 0);
        chk("idle_addr", ADDR, 0);
        chk("idle_wdata", Data_BUS_WRITE, 0);
      end
    end
  endtask
  task automatic fill();
    for (int i = 0; i < 128; i++) imem[i] = 32'h0000064f;
  endtask
  task automatic push(input int c, input logic w, input logic [31:0] a, input logic [31:0] dd);
    mop_t e;
    e.cyc = c; e.we = w; e.addr = a; e.data = dd;
    sb.push_back(e);
  endtask

  initial begin
    fill();
    do_reset(5);
    run(10);
    fill();
    imem[0] = it(6'h08, 0, 1, 16'd5);
    imem[1] = it(6'h08, 0, 2, 16'd7);
    imem[5] = rt(6'h00, 6'h20, 1, 2, 3);
    imem[9] = it(6'h2b, 0, 3, 16'h10);
    imem[10] = it(6'h23, 0, 4, 16'h4);
    imem[14] = it(6'h2b, 0, 4, 16'h8);
    imem[15] = it(6'h08, 0, 6, 16'hffff);
    imem[16] = it(6'h08, 0, 7, 16'd3);
    imem[20] = rt(6'h1c, 6'h02, 6, 7, 5);
    imem[21] = rt(6'h00, 6'h2a, 6, 7, 8);
    imem[22] = rt(6'h00, 6'h22, 7, 6, 9);
    imem[23] = rt(6'h00, 6'h24, 6, 7, 10);
    imem[24] = rt(6'h00, 6'h25, 1, 2, 11);
    imem[27] = it(6'h2b, 0, 5, 16'h20);
    imem[28] = it(6'h2b, 0, 8, 16'h24);
    imem[29] = it(6'h2b, 0, 9, 16'h28);
    imem[30] = it(6'h2b, 0, 10, 16'h2c);
    imem[31] = it(6'h2b, 0, 11, 16'h30);
    imem[32] = rt(6'h00, 6'h0f, 1, 2, 12);
    imem[35] = it(6'h2b, 0, 12, 16'h34);
    imem[36] = it(6'h08, 0, 0, 16'd9);
    imem[39] = it(6'h2b, 1, 0, 16'h38);
    imem[40] = it(6'h08, 0, 13, 16'h1234);
    imem[43] = it(6'h2b, 0, 13, 16'h40);
    push(12, 1, 32'h10, 32'd12);
    push(13, 0, 32'h4, 32'h0);
    push(17, 1, 32'h8, 32'h22b4);
    push(30, 1, 32'h20, 32'hfffffffd);
    push(31, 1, 32'h24, 32'd1);
    push(32, 1, 32'h28, 32'd4);
    push(33, 1, 32'h2c, 32'd3);
    push(34, 1, 32'h30, 32'd7);
    push(38, 1, 32'h34, 32'd0);
    push(42, 1, 32'h3d, 32'd0);
    push(46, 1, 32'h40, 32'h1234);
    do_reset(2);
    run(50);
    chk("sb_left_a", 32'(sb.size()), 0);
    fill();
    br = 1'b1;
    imem[8] = it(6'h04, 0, 0, 16'd2);
    imem[9] = it(6'h08, 0, 1, 16'h55);
    imem[10] = it(6'h08, 0, 1, 16'h66);
    imem[11] = {6'h02, 26'h40};
    imem[12] = it(6'h08, 0, 1, 16'h77);
    imem[66] = it(6'h2b, 0, 1, 16'h50);
    push(18, 1, 32'h50, 32'd0);
    do_reset(2);
    run(22);
    chk("sb_left_b", 32'(sb.size()), 0);
    do_reset(1);
    run(16);
    reset = 1'b1;
    @(negedge CLK);
    reset_chk();
    reset = 1'b0;
    run(8);
    chk("sb_left_c", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
